// File: rtl/ram8_stack_ctrl_pkg.sv
// Shared definitions for the RAM-backed LIFO controller: op codes, FSM states, data width.
package ram8_stack_pkg;

  localparam int DW = 8;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ram8_stack_ctrl_if.sv
// Request/response channel of the stack controller.
// master: the requester (drives req_*, consumes rsp_*); slave: the controller.
interface ram8_stack_ctrl_if;
  import ram8_stack_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/ram8_stack_ctrl_ptr.sv
// Stack pointer: saturating up/down counter with clear, plus empty/full flags.
module ram8_stack_ptr #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic        dec,
  output logic [AW:0] count,
  output logic        empty,
  output logic        full
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Entry count; guarded so it can never wrap in either direction.
  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (clr)           count <= '0;
    else if (inc && !full)  count <= count + 1'b1;
    else if (dec && !empty) count <= count - 1'b1;
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/ram8_stack_ctrl.sv
// LIFO controller in front of a 256x8 RAM (write on negedge, combinational read).
// Optional feature macro: STACK_PEEK_EN enables op 10 (peek); otherwise peek is rejected.
//
// state | meaning
// IDLE  | ready for a request; errors and clear go straight to RESP
// WRITE | mem_save at address count, count increments on exit
// READ  | mem_load at address count-1, captures read data (pop decrements)
// RESP  | holds rsp_valid/data/err until rsp_ready
module ram8_stack_ctrl
  import ram8_stack_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ram8_stack_ctrl_if.slave       bus,
  output logic [AW-1:0]          mem_address,
  output logic                   mem_load,
  output logic                   mem_save,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  output logic [AW:0]            count,
  output logic                   empty,
  output logic                   full
);

  state_t        state, state_nxt;
  logic [DW-1:0] data_q;
  logic [1:0]    op_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;
  logic          accept, acc_err;
  logic          cnt_inc, cnt_dec, cnt_clr;
  logic          peek_ok;

`ifdef STACK_PEEK_EN
  assign peek_ok = 1'b1;
`else
  assign peek_ok = 1'b0;
`endif

  ram8_stack_ptr #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .dec   (cnt_dec),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake and RAM strobes; RAM outputs depend only on registered values.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    acc_err       = 1'b0;
    cnt_inc       = 1'b0;
    cnt_dec       = 1'b0;
    cnt_clr       = 1'b0;
    mem_load      = 1'b0;
    mem_save      = 1'b0;
    mem_address   = '0;
    mem_wdata     = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          case (bus.req_op)
            OP_PUSH: begin
              if (full) begin
                acc_err   = 1'b1;
                state_nxt = ST_RESP;
              end else begin
                state_nxt = ST_WRITE;
              end
            end
            OP_POP: begin
              if (empty) begin
                acc_err   = 1'b1;
                state_nxt = ST_RESP;
              end else begin
                state_nxt = ST_READ;
              end
            end
            OP_PEEK: begin
              if (!peek_ok || empty) begin
                acc_err   = 1'b1;
                state_nxt = ST_RESP;
              end else begin
                state_nxt = ST_READ;
              end
            end
            default: begin
              cnt_clr   = 1'b1;
              state_nxt = ST_RESP;
            end
          endcase
        end
      end
      ST_WRITE: begin
        mem_save    = 1'b1;
        mem_address = count[AW-1:0];
        mem_wdata   = data_q;
        cnt_inc     = 1'b1;
        state_nxt   = ST_RESP;
      end
      ST_READ: begin
        mem_load    = 1'b1;
        mem_address = AW'(count - 1'b1);
        cnt_dec     = (op_q == OP_POP);
        state_nxt   = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and response registers; rsp_* stay frozen while in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      op_q       <= OP_PUSH;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        data_q     <= bus.req_data;
        op_q       <= bus.req_op;
        rsp_data_q <= '0;
        rsp_err_q  <= acc_err;
      end
      if (state == ST_READ) rsp_data_q <= mem_rdata;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;

endmodule
